// File: rtl/dma_channel_arbiter_if.sv
// Interface: dma_channel_arbiter_if
// Request, arbitration and hold-handshake signals that run between the DMA arbiter,
// the channel devices, the CPU hold logic and the transfer engine.
//   dreq[3:0]     channel requests, active-high, level
//   mask[3:0]     1 = channel ignored for arbitration
//   rot_pri       1 = rotating priority (only honoured when ROTATE_PRI_EN is defined)
//   hlda          CPU hold acknowledge
//   xfer_done     one-cycle end-of-service pulse from the transfer engine
//   hrq           hold request to the CPU
//   dack[3:0]     channel acknowledges, active-low, at most one low
//   grant_valid   high while a channel owns the bus
//   grant_ch[1:0] granted / pending-winner channel number
//   abort         one-cycle pulse: hlda revoked during a grant
//   timeout_err   one-cycle pulse: hold request watchdog expired
// Modports: slave = arbiter side, master = environment side.
interface dma_channel_arbiter_if;
  logic [3:0] dreq;
  logic [3:0] mask;
  logic       rot_pri;
  logic       hlda;
  logic       xfer_done;
  logic       hrq;
  logic [3:0] dack;
  logic       grant_valid;
  logic [1:0] grant_ch;
  logic       abort;
  logic       timeout_err;

  modport slave (
    input  dreq, mask, rot_pri, hlda, xfer_done,
    output hrq, dack, grant_valid, grant_ch, abort, timeout_err
  );

  modport master (
    output dreq, mask, rot_pri, hlda, xfer_done,
    input  hrq, dack, grant_valid, grant_ch, abort, timeout_err
  );
endinterface

// File: rtl/dma_channel_arbiter.sv
// Module: dma_channel_arbiter
// Bus-ownership sequencer and four-channel arbiter in front of an 8237-style DMA engine.
// Picks the highest-priority unmasked request, runs the HRQ/HLDA hold handshake with the
// CPU, drives one active-low DACK while the channel owns the bus and releases the bus on
// xfer_done (normal end), on hlda loss (abort) or on hold-request watchdog expiry.
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous active-high reset
//   bus    dma_channel_arbiter_if.slave (requests, handshake, grant outputs)
// Parameters:
//   HOLD_TIMEOUT  cycles in REQ without hlda before giving up; 0 disables the watchdog
//   CNT_W         watchdog counter width, must hold HOLD_TIMEOUT
// Build option:
//   ROTATE_PRI_EN  when defined, builds a priority pointer; with rot_pri=1 the channel just
//                  completed becomes lowest priority. Undefined: fixed order ch0..ch3.
module dma_channel_arbiter #(
  parameter int unsigned HOLD_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 8
) (
  input logic                  clk,
  input logic                  reset,
  dma_channel_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StGrant, StRelease} state_e;

  localparam bit              WdogEn   = (HOLD_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WdogLast = CNT_W'(HOLD_TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] wdog;
  logic             hrq_q;
  logic [3:0]       dack_q;
  logic             grant_valid_q;
  logic [1:0]       grant_ch_q;
  logic             abort_q;
  logic             timeout_q;

  logic [3:0]       pending;
  logic [1:0]       winner;
  logic [1:0]       sel_ch;
  logic [1:0]       pri_ptr;

`ifndef ROTATE_PRI_EN
  // Fixed priority: ch0 is always searched first.
  assign pri_ptr = 2'd0;
`endif

  assign pending = bus.dreq & ~bus.mask;

  // Search starting at the pointer, wrapping ch3 -> ch0.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = pri_ptr + 2'(i);
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // On hlda in REQ, a request withdrawn that same cycle still grants the latched channel.
  assign sel_ch = (pending != 4'b0) ? winner : grant_ch_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      wdog          <= '0;
      hrq_q         <= 1'b0;
      dack_q        <= 4'b1111;
      grant_valid_q <= 1'b0;
      grant_ch_q    <= 2'd0;
      abort_q       <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef ROTATE_PRI_EN
      pri_ptr       <= 2'd0;
`endif
    end else begin
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state)
        StIdle: begin
          if (pending != 4'b0) begin
            grant_ch_q <= winner;
            hrq_q      <= 1'b1;
            wdog       <= '0;
            state      <= StReq;
          end
        end
        StReq: begin
          // Re-evaluated every cycle so a late higher-priority request preempts.
          if (pending != 4'b0) grant_ch_q <= winner;
          if (bus.hlda) begin
            grant_ch_q    <= sel_ch;
            dack_q        <= ~(4'b0001 << sel_ch);
            grant_valid_q <= 1'b1;
            state         <= StGrant;
          end else if (pending == 4'b0) begin
            state <= StRelease;
          end else if (WdogEn && (wdog == WdogLast)) begin
            timeout_q <= 1'b1;
            state     <= StRelease;
          end else if (wdog != '1) begin
            wdog <= wdog + CNT_W'(1);
          end
        end
        StGrant: begin
          // xfer_done takes precedence over an hlda drop in the same cycle.
          if (bus.xfer_done) begin
            dack_q        <= 4'b1111;
            grant_valid_q <= 1'b0;
            state         <= StRelease;
`ifdef ROTATE_PRI_EN
            if (bus.rot_pri) pri_ptr <= grant_ch_q + 2'd1;
            else             pri_ptr <= 2'd0;
`endif
          end else if (!bus.hlda) begin
            abort_q       <= 1'b1;
            dack_q        <= 4'b1111;
            grant_valid_q <= 1'b0;
            state         <= StRelease;
          end
        end
        StRelease: begin
          hrq_q <= 1'b0;
          if (!bus.hlda) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.hrq         = hrq_q;
  assign bus.dack        = dack_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_ch    = grant_ch_q;
  assign bus.abort       = abort_q;
  assign bus.timeout_err = timeout_q;

endmodule
